// File: rtl/register_file.sv
// Architectural register file R0..R3 with pending-result tags; renames from two dispatch slots, captures from three result buses.
// Single-cycle update on rising clk; outputs are flop values only; no backpressure, buses and dispatch are accepted every cycle.
module register_file #(
    parameter int DW   = 32,
    parameter int TW   = 8,
    parameter int NREG = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TW+DW-1:0] loadbus,
    input  logic [TW+DW-1:0] multbus,
    input  logic [TW+DW-1:0] addbus,
    input  logic [TW+DW-1:0] instbus1,
    input  logic [TW+DW-1:0] instbus2,
    output logic [DW-1:0]    reg0,
    output logic [DW-1:0]    reg1,
    output logic [DW-1:0]    reg2,
    output logic [DW-1:0]    reg3,
    output logic [TW-1:0]    tag0,
    output logic [TW-1:0]    tag1,
    output logic [TW-1:0]    tag2,
    output logic [TW-1:0]    tag3
);

    localparam logic [TW-1:0] OP_LOAD  = TW'(8'h01);
    localparam logic [TW-1:0] OP_ADD   = TW'(8'h03);
    localparam logic [TW-1:0] OP_MULTI = TW'(8'h04);
    localparam logic [TW-1:0] REG_BASE = TW'(8'h10);
    localparam logic [TW-1:0] NO_TAG   = '0;

    logic [DW-1:0] data_q [NREG];
    logic [DW-1:0] data_d [NREG];
    logic [TW-1:0] tag_q  [NREG];
    logic [TW-1:0] tag_d  [NREG];

    logic [TW-1:0] ld_tag, mu_tag, ad_tag;
    logic [DW-1:0] ld_dat, mu_dat, ad_dat;
    logic [TW-1:0] i1_tag, i1_op, i1_dest;
    logic [TW-1:0] i2_tag, i2_op, i2_dest;
    logic          i1_ren, i2_ren;

    assign {ld_tag, ld_dat} = loadbus;
    assign {mu_tag, mu_dat} = multbus;
    assign {ad_tag, ad_dat} = addbus;

    // Dispatch word layout: {tag, op, srcA, srcB, dest}; sources are not used here.
    assign i1_tag  = instbus1[TW+DW-1 -: TW];
    assign i1_op   = instbus1[DW-1 -: TW];
    assign i1_dest = instbus1[TW-1:0];
    assign i2_tag  = instbus2[TW+DW-1 -: TW];
    assign i2_op   = instbus2[DW-1 -: TW];
    assign i2_dest = instbus2[TW-1:0];

    assign i1_ren = (i1_op == OP_LOAD) || (i1_op == OP_ADD) || (i1_op == OP_MULTI);
    assign i2_ren = (i2_op == OP_LOAD) || (i2_op == OP_ADD) || (i2_op == OP_MULTI);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];

            // Lowest-priority bus first so that load ends up winning a shared tag.
            if (ad_tag != NO_TAG && ad_tag == tag_q[i]) begin
                data_d[i] = ad_dat;
                tag_d[i]  = NO_TAG;
            end
            if (mu_tag != NO_TAG && mu_tag == tag_q[i]) begin
                data_d[i] = mu_dat;
                tag_d[i]  = NO_TAG;
            end
            if (ld_tag != NO_TAG && ld_tag == tag_q[i]) begin
                data_d[i] = ld_dat;
                tag_d[i]  = NO_TAG;
            end

            // Renames after capture: the register keeps the fresh data but stays pending.
            if (i1_ren && i1_dest == REG_BASE + TW'(i)) begin
                tag_d[i] = i1_tag;
            end
            if (i2_ren && i2_dest == REG_BASE + TW'(i)) begin
                tag_d[i] = i2_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign reg0 = data_q[0];
    assign reg1 = data_q[1];
    assign reg2 = data_q[2];
    assign reg3 = data_q[3];
    assign tag0 = tag_q[0];
    assign tag1 = tag_q[1];
    assign tag2 = tag_q[2];
    assign tag3 = tag_q[3];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expectations queued with each stimulus cycle, compared after the edge.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [39:0] loadbus, multbus, addbus, instbus1, instbus2;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [7:0]  tag0, tag1, tag2, tag3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb [$];

    register_file dut (
        .clk(clk), .rst(rst),
        .loadbus(loadbus), .multbus(multbus), .addbus(addbus),
        .instbus1(instbus1), .instbus2(instbus2),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .tag0(tag0), .tag1(tag1), .tag2(tag2), .tag3(tag3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] get_out(input logic [2:0] sel);
        case (sel)
            3'd0: get_out = reg0;
            3'd1: get_out = reg1;
            3'd2: get_out = reg2;
            3'd3: get_out = reg3;
            3'd4: get_out = {24'h0, tag0};
            3'd5: get_out = {24'h0, tag1};
            3'd6: get_out = {24'h0, tag2};
            default: get_out = {24'h0, tag3};
        endcase
    endfunction

    task automatic push_exp(input logic [2:0] sel, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_reg(input int r, input logic [31:0] d, input logic [7:0] t);
        push_exp(3'(r), d);
        push_exp(3'(r + 4), {24'h0, t});
    endtask

    task automatic drain(input string phase);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("%s.%s%0d", phase, (e.sel < 3'd4) ? "reg" : "tag", e.sel[1:0]),
                     get_out(e.sel), e.val);
        end
    endtask

    function automatic logic [39:0] ib(input logic [7:0] t, input logic [7:0] op, input logic [7:0] d);
        ib = {t, op, 8'h00, 8'h00, d};
    endfunction

    function automatic logic [39:0] rb(input logic [7:0] t, input logic [31:0] d);
        rb = {t, d};
    endfunction

    // One clock with the given bus values, then compare everything queued for it.
    task automatic cyc(input string phase, input logic [39:0] l, input logic [39:0] m,
                       input logic [39:0] a, input logic [39:0] i1, input logic [39:0] i2);
        @(negedge clk);
        loadbus  = l;
        multbus  = m;
        addbus   = a;
        instbus1 = i1;
        instbus2 = i2;
        @(posedge clk);
        #1;
        drain(phase);
    endtask

    localparam logic [39:0] IDLE = 40'h0;

    initial begin
        rst = 1'b1;
        loadbus = '0; multbus = '0; addbus = '0; instbus1 = '0; instbus2 = '0;
        #2;
        for (int r = 0; r < 4; r++) exp_reg(r, 32'h0, 8'h00);
        drain("por");
        #10;
        rst = 1'b0;

        // Rename R2 to M0, then broadcast on the multiplier bus.
        exp_reg(2, 32'h0, 8'h30);
        cyc("ren2", IDLE, IDLE, IDLE, ib(8'h30, 8'h04, 8'h12), IDLE);
        exp_reg(2, 32'h34561234, 8'h00);
        cyc("cap2", IDLE, rb(8'h30, 32'h34561234), IDLE, IDLE, IDLE);

        // Load path through slot 2.
        exp_reg(1, 32'h0, 8'h40);
        cyc("ren1", IDLE, IDLE, IDLE, IDLE, ib(8'h40, 8'h01, 8'h11));
        exp_reg(0, 32'h0, 8'h00);
        exp_reg(1, 32'hABCEDE23, 8'h00);
        exp_reg(2, 32'h34561234, 8'h00);
        exp_reg(3, 32'h0, 8'h00);
        cyc("ld1", rb(8'h40, 32'hABCEDE23), IDLE, IDLE, IDLE, IDLE);

        // Both slots target R3: younger slot wins.
        exp_reg(3, 32'h0, 8'h31);
        cyc("dual3", IDLE, IDLE, IDLE, ib(8'h20, 8'h03, 8'h13), ib(8'h31, 8'h04, 8'h13));

        // STORE and out-of-range dest leave every tag alone.
        exp_reg(0, 32'h0, 8'h00);
        exp_reg(3, 32'h0, 8'h31);
        cyc("store0", IDLE, IDLE, IDLE, ib(8'h50, 8'h02, 8'h10), ib(8'h22, 8'h03, 8'h14));

        exp_reg(3, 32'h00000077, 8'h00);
        cyc("cap3", IDLE, rb(8'h31, 32'h77), IDLE, IDLE, IDLE);

        // Capture and rename on R0 in the same edge.
        exp_reg(0, 32'h0, 8'h21);
        cyc("ren0", IDLE, IDLE, IDLE, ib(8'h21, 8'h03, 8'h10), IDLE);
        exp_reg(0, 32'hDEADBEEF, 8'h41);
        cyc("capren0", IDLE, IDLE, rb(8'h21, 32'hDEADBEEF), ib(8'h41, 8'h01, 8'h10), IDLE);

        // One broadcast updates two registers sharing a tag.
        exp_reg(1, 32'hABCEDE23, 8'h22);
        exp_reg(2, 32'h34561234, 8'h22);
        cyc("ren12", IDLE, IDLE, IDLE, ib(8'h22, 8'h03, 8'h11), ib(8'h22, 8'h03, 8'h12));
        exp_reg(1, 32'h5, 8'h00);
        exp_reg(2, 32'h5, 8'h00);
        cyc("bcast", IDLE, IDLE, rb(8'h22, 32'h5), IDLE, IDLE);

        // Tag-00 buses are idle even with nonzero data.
        exp_reg(0, 32'hDEADBEEF, 8'h41);
        exp_reg(1, 32'h5, 8'h00);
        exp_reg(2, 32'h5, 8'h00);
        exp_reg(3, 32'h77, 8'h00);
        cyc("idle", rb(8'h00, 32'hFFFFFFFF), rb(8'h00, 32'hFFFFFFFF), rb(8'h00, 32'hFFFFFFFF), IDLE, IDLE);

        // Bus priority: load over add, mult over add.
        exp_reg(3, 32'h77, 8'h20);
        exp_reg(1, 32'h5, 8'h30);
        cyc("renp", IDLE, IDLE, IDLE, ib(8'h20, 8'h03, 8'h13), ib(8'h30, 8'h04, 8'h11));
        exp_reg(3, 32'h11112222, 8'h00);
        cyc("prio_la", rb(8'h20, 32'h11112222), IDLE, rb(8'h20, 32'h33334444), IDLE, IDLE);
        exp_reg(1, 32'h0000AAAA, 8'h00);
        cyc("prio_ma", IDLE, rb(8'h30, 32'hAAAA), rb(8'h30, 32'hBBBB), IDLE, IDLE);

        // Mid-run async reset away from any rising edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int r = 0; r < 4; r++) exp_reg(r, 32'h0, 8'h00);
        drain("arst");
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
